// File: rtl/mpmc10_req_unloader.sv
// mpmc10 request FIFO read-side unloader.
// Hides the FIFO read latency and feeds the MC state machine one request per clock.
package mpmc10_pkg;
  typedef struct packed {
    logic [3:0]   cid;
    logic [7:0]   tid;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  addr;
    logic [127:0] dat;
  } wb_write_request128_t;

  localparam int REQW = $bits(wb_write_request128_t);
endpackage

module mpmc10_req_unloader
  import mpmc10_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int CNTW      = $clog2(BUF_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty,
  input  logic            fifo_rd_rst_busy,
  input  logic            fifo_v,
  input  logic [REQW-1:0] fifo_dout,
  output logic            fifo_rd,
  input  logic            flush,
  output logic [REQW-1:0] req_o,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [CNTW-1:0] level,
  output logic            err_spurious
);

  localparam int PTRW = $clog2(BUF_DEPTH);
  localparam int SUMW = CNTW + 1;
  localparam logic [PTRW-1:0] LAST = PTRW'(BUF_DEPTH - 1);

  logic [REQW-1:0] buf_q [BUF_DEPTH];
  logic [CNTW-1:0] occ_q, occ_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic            inflight_q;
  logic            drop_next_q;
  logic            err_q;
  logic            push, pop;
  logic [SUMW-1:0] proj;

  assign req_valid    = (occ_q != '0);
  assign pop          = req_valid & req_ready;
  assign req_o        = buf_q[rd_ptr_q];
  assign level        = occ_q;
  assign err_spurious = err_q;

  // Count the in-flight word so its arrival always finds a free slot.
  assign proj = SUMW'(occ_q) - SUMW'(pop) + SUMW'(inflight_q);

  assign fifo_rd = ~fifo_empty & ~fifo_rd_rst_busy & ~flush & rst
                 & (proj < SUMW'(BUF_DEPTH));

  assign push = fifo_v & inflight_q & ~drop_next_q & ~flush;

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push)
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTRW'(1);
      if (pop)
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTRW'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + CNTW'(1);
        2'b01:   occ_d = occ_q - CNTW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      drop_next_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= fifo_rd;
      drop_next_q <= 1'b0;
      err_q       <= err_q | (fifo_v & ~inflight_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++)
        buf_q[i] <= '0;
    end else if (push) begin
      buf_q[wr_ptr_q] <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_mpmc10_req_unloader.sv
// Directed bench for mpmc10_req_unloader.
// A behavioural one-cycle-latency FIFO feeds the DUT.
module tb_mpmc10_req_unloader;
  import mpmc10_pkg::*;

  localparam int BUF_DEPTH = 2;
  localparam int CNTW = $clog2(BUF_DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            fifo_empty;
  logic            fifo_rd_rst_busy = 1'b0;
  logic            fifo_v;
  logic [REQW-1:0] fifo_dout;
  logic            fifo_rd;
  logic            flush = 1'b0;
  logic [REQW-1:0] req_o;
  logic            req_valid;
  logic            req_ready = 1'b0;
  logic [CNTW-1:0] level;
  logic            err_spurious;

  logic [REQW-1:0] q[$];
  int              pushed_n = 0;
  int              popped_n = 0;
  int              rd_cnt = 0;
  logic            fifo_v_m = 1'b0;
  logic [REQW-1:0] dout_m = '0;
  logic            inj_v = 1'b0;
  logic [REQW-1:0] inj_dat = '0;

  int checks = 0;
  int errors = 0;

  wb_write_request128_t ro;
  assign ro = wb_write_request128_t'(req_o);

  assign fifo_empty = (pushed_n == popped_n);
  assign fifo_v     = fifo_v_m | inj_v;
  assign fifo_dout  = inj_v ? inj_dat : dout_m;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    fifo_v_m <= fifo_rd;
    if (fifo_rd) begin
      dout_m   <= q.pop_front();
      popped_n <= popped_n + 1;
      rd_cnt   <= rd_cnt + 1;
    end
  end

  mpmc10_req_unloader #(.BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_rst_busy(fifo_rd_rst_busy),
    .fifo_v(fifo_v),
    .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd),
    .flush(flush),
    .req_o(req_o),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .level(level),
    .err_spurious(err_spurious)
  );

  function automatic logic [REQW-1:0] mk(input logic [31:0] a);
    wb_write_request128_t r;
    r      = '0;
    r.addr = a;
    r.tid  = a[11:4];
    r.we   = 1'b1;
    r.sel  = '1;
    r.dat  = {a, ~a, a, ~a};
    return r;
  endfunction

  task automatic push_e(input logic [31:0] a);
    q.push_back(mk(a));
    pushed_n++;
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (fifo_rd !== 1'b0) begin
      errors++; $display("FAIL rst_fifo_rd got=%0b exp=0", fifo_rd);
    end
    checks++;
    if (req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got=%0b exp=0", req_valid);
    end
    checks++;
    if (level !== '0) begin
      errors++; $display("FAIL rst_level got=%0d exp=0", level);
    end
    checks++;
    if (req_o !== '0) begin
      errors++; $display("FAIL rst_req_o got=%0h exp=0", req_o);
    end
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++; $display("FAIL rst_err got=%0b exp=0", err_spurious);
    end
    rst = 1'b1;
    @(negedge clk);
    base = rd_cnt;
    push_e(32'h1000);
    #1;
    checks++;
    if (fifo_rd !== 1'b1) begin
      errors++; $display("FAIL first_rd got=%0b exp=1", fifo_rd);
    end
    @(negedge clk);
    checks++;
    if (fifo_rd !== 1'b0 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat1 rd=%0b valid=%0b exp=0/0", fifo_rd, req_valid);
    end
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1) begin
      errors++; $display("FAIL lat2_valid got=%0b exp=1", req_valid);
    end
    checks++;
    if (ro.addr !== 32'h1000) begin
      errors++; $display("FAIL lat2_addr got=%0h exp=1000", ro.addr);
    end
    checks++;
    if (level !== CNTW'(1)) begin
      errors++; $display("FAIL lat2_level got=%0d exp=1", level);
    end
    checks++;
    if (rd_cnt - base !== 1) begin
      errors++; $display("FAIL rd_pulses got=%0d exp=1", rd_cnt - base);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL pop1 valid=%0b level=%0d exp=0/0", req_valid, level);
    end
  endtask

  task automatic test_back_to_back();
    int base, k, first, last;
    req_ready = 1'b1;
    base = rd_cnt;
    for (int i = 0; i < 8; i++) push_e(32'(i * 16));
    k = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      #1;
      if (req_valid) begin
        checks++;
        if (ro.addr !== 32'(k * 16)) begin
          errors++;
          $display("FAIL b2b_order got=%0h exp=%0h", ro.addr, k * 16);
        end
        if (first < 0) first = cyc;
        last = cyc;
        k++;
      end
      @(negedge clk);
    end
    req_ready = 1'b0;
    checks++;
    if (k !== 8) begin
      errors++; $display("FAIL b2b_count got=%0d exp=8", k);
    end
    checks++;
    if (last - first !== 7) begin
      errors++; $display("FAIL b2b_span got=%0d exp=7", last - first);
    end
    checks++;
    if (rd_cnt - base !== 8) begin
      errors++; $display("FAIL b2b_rd got=%0d exp=8", rd_cnt - base);
    end
  endtask

  task automatic test_backpressure();
    int base, k;
    req_ready = 1'b0;
    base = rd_cnt;
    for (int i = 0; i < 5; i++) push_e(32'h200 + 32'(i * 16));
    repeat (3) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_valid !== 1'b1 || ro.addr !== 32'h200 || fifo_rd !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold v=%0b addr=%0h rd=%0b exp=1/200/0",
                 req_valid, ro.addr, fifo_rd);
      end
      @(negedge clk);
    end
    checks++;
    if (rd_cnt - base !== BUF_DEPTH) begin
      errors++; $display("FAIL bp_rd got=%0d exp=%0d", rd_cnt - base, BUF_DEPTH);
    end
    checks++;
    if (level !== CNTW'(BUF_DEPTH)) begin
      errors++; $display("FAIL bp_level got=%0d exp=%0d", level, BUF_DEPTH);
    end
    req_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 30 && k < 5; cyc++) begin
      #1;
      if (req_valid) begin
        checks++;
        if (ro.addr !== 32'h200 + 32'(k * 16)) begin
          errors++;
          $display("FAIL bp_order got=%0h exp=%0h", ro.addr, 32'h200 + k * 16);
        end
        k++;
      end
      @(negedge clk);
    end
    req_ready = 1'b0;
    checks++;
    if (k !== 5) begin
      errors++; $display("FAIL bp_count got=%0d exp=5", k);
    end
  endtask

  task automatic test_wrap();
    int k;
    for (int i = 0; i < 6; i++) push_e(32'h400 + 32'(i * 16));
    k = 0;
    for (int cyc = 0; cyc < 60 && k < 6; cyc++) begin
      req_ready = (cyc % 2 == 0);
      #1;
      checks++;
      if (level > CNTW'(BUF_DEPTH)) begin
        errors++; $display("FAIL wrap_level got=%0d exp<=%0d", level, BUF_DEPTH);
      end
      if (req_valid && req_ready) begin
        checks++;
        if (ro.addr !== 32'h400 + 32'(k * 16)) begin
          errors++;
          $display("FAIL wrap_order got=%0h exp=%0h", ro.addr, 32'h400 + k * 16);
        end
        k++;
      end
      @(negedge clk);
    end
    req_ready = 1'b0;
    checks++;
    if (k !== 6 || level !== '0) begin
      errors++; $display("FAIL wrap_end count=%0d level=%0d exp=6/0", k, level);
    end
  endtask

  task automatic test_flush();
    int k;
    req_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_e(32'h500 + 32'(i * 16));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (level !== CNTW'(1) || fifo_v !== 1'b1) begin
      errors++;
      $display("FAIL fl_pre level=%0d v=%0b exp=1/1", level, fifo_v);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (fifo_rd !== 1'b0) begin
      errors++; $display("FAIL fl_rd got=%0b exp=0", fifo_rd);
    end
    @(negedge clk);
    checks++;
    if (level !== '0 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL fl_post level=%0d valid=%0b exp=0/0", level, req_valid);
    end
    flush = 1'b0;
    req_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 30 && k < 3; cyc++) begin
      #1;
      if (req_valid) begin
        checks++;
        if (ro.addr !== 32'h520 + 32'(k * 16)) begin
          errors++;
          $display("FAIL fl_order got=%0h exp=%0h", ro.addr, 32'h520 + k * 16);
        end
        k++;
      end
      @(negedge clk);
    end
    req_ready = 1'b0;
    checks++;
    if (k !== 3 || level !== '0) begin
      errors++; $display("FAIL fl_end count=%0d level=%0d exp=3/0", k, level);
    end
  endtask

  task automatic test_spurious_busy();
    req_ready = 1'b0;
    push_e(32'h600);
    repeat (3) @(negedge clk);
    checks++;
    if (level !== CNTW'(1) || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL sp_pre level=%0d err=%0b exp=1/0", level, err_spurious);
    end
    inj_v = 1'b1;
    inj_dat = mk(32'hdead0);
    @(negedge clk);
    inj_v = 1'b0;
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++; $display("FAIL sp_err got=%0b exp=1", err_spurious);
    end
    checks++;
    if (level !== CNTW'(1) || ro.addr !== 32'h600) begin
      errors++;
      $display("FAIL sp_keep level=%0d addr=%0h exp=1/600", level, ro.addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++; $display("FAIL sp_sticky got=%0b exp=1", err_spurious);
    end
    fifo_rd_rst_busy = 1'b1;
    for (int i = 0; i < 3; i++) push_e(32'h610 + 32'(i * 16));
    req_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (fifo_rd !== 1'b0) begin
        errors++; $display("FAIL busy_rd got=%0b exp=0", fifo_rd);
      end
      @(negedge clk);
    end
    checks++;
    if (level !== '0) begin
      errors++; $display("FAIL busy_drain got=%0d exp=0", level);
    end
    fifo_rd_rst_busy = 1'b0;
    #1;
    checks++;
    if (fifo_rd !== 1'b1) begin
      errors++; $display("FAIL busy_rel got=%0b exp=1", fifo_rd);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || ro.addr !== 32'h610) begin
      errors++;
      $display("FAIL mid_pre v=%0b addr=%0h exp=1/610", req_valid, ro.addr);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (req_valid !== 1'b0 || level !== '0 || fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL arst v=%0b level=%0d rd=%0b exp=0/0/0",
               req_valid, level, fifo_rd);
    end
    checks++;
    if (req_o !== '0 || err_spurious !== 1'b0) begin
      errors++;
      $display("FAIL arst_o req_o=%0h err=%0b exp=0/0", req_o, err_spurious);
    end
    req_ready = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    pushed_n = popped_n;
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_flush();
    test_spurious_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
